// File: rtl/ne16_normquant_stream.sv
// NE16 normalisation/quantisation stream stage.
// Three-stage elastic pipeline: multiply, combine+round, shift/ReLU/saturate.
// Per-beat control travels with the data so modes may change beat to beat.

// Per-lane shift, ReLU and saturation (purely combinational).
module ne16_nq_lane #(
  parameter int INT = 65,
  parameter int SHW = 6
) (
  input  logic signed [INT-1:0] comb_i,
  input  logic [SHW-1:0]        shift_i,
  input  logic                  relu_i,
  input  logic [1:0]            qbits_i,
  input  logic                  qsigned_i,
  input  logic                  active_i,
  output logic [31:0]           data_o,
  output logic                  sat_o
);
  localparam logic signed [INT-1:0] ONE = {{(INT-1){1'b0}}, 1'b1};

  logic signed [INT-1:0] v, hi, lo, q;
  logic                  sat;
  int                    qw;

  // Arithmetic shift, optional ReLU, then clamp to the selected output range.
  always_comb begin
    v = comb_i >>> shift_i;
    if (relu_i && v[INT-1]) v = '0;
    case (qbits_i)
      2'b01:   qw = 16;
      2'b10:   qw = 32;
      default: qw = 8;
    endcase
    hi  = qsigned_i ? (ONE <<< (qw - 1)) - ONE : (ONE <<< qw) - ONE;
    lo  = qsigned_i ? -(ONE <<< (qw - 1)) : '0;
    q   = v;
    sat = 1'b0;
    if (v > hi) begin
      q   = hi;
      sat = 1'b1;
    end else if (v < lo) begin
      q   = lo;
      sat = 1'b1;
    end
    // Clamped value fits in q bits, so its low 32 bits are already sign/zero extended.
    data_o = active_i ? q[31:0] : '0;
    sat_o  = active_i & sat;
  end
endmodule

module ne16_normquant_stream #(
  parameter int NMULT = 4,
  parameter int NMS   = 8,
  parameter int ACC   = 32,
  parameter int SHW   = 6,
  parameter int CNTW  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [NMULT*ACC-1:0]  accumulator_i,
  input  logic [NMULT*NMS-1:0]  norm_mult_i,
  input  logic [NMULT*SHW-1:0]  shift_i,
  input  logic [1:0]            mode_i,
  input  logic                  norm_signed_i,
  input  logic                  round_i,
  input  logic                  relu_i,
  input  logic [1:0]            qbits_i,
  input  logic                  qsigned_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [NMULT*32-1:0]   data_o,
  output logic [NMULT-1:0]      sat_o,
  output logic [CNTW-1:0]       sat_count_o
);
  localparam int INT = ACC + 4*NMS + 1;
  localparam int PW  = ACC + NMS + 1;
  localparam int LW  = $clog2(NMULT);
  localparam logic signed [INT-1:0] ONE = {{(INT-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [NMULT-1:0][SHW-1:0] shift;
    logic                      relu;
    logic [1:0]                qbits;
    logic                      qsigned;
  } qctl_t;

  typedef struct packed {
    logic [1:0] mode;
    logic       rnd;
    qctl_t      q;
  } ctl_t;

  logic [NMULT-1:0][ACC-1:0] acc_w;
  logic [NMULT-1:0][NMS-1:0] nm_w;
  logic [3:1]                vld_q;
  logic                      rdy1, rdy2, rdy3;
  ctl_t                      ctl_in, ctl1_q;
  qctl_t                     ctl2_q;
  logic [NMULT-1:0][PW-1:0]  prod_d, prod_q;
  logic [NMULT-1:0][INT-1:0] comb_d, comb_q;
  logic [NMULT-1:0]          act_d, act_q;
  logic [NMULT-1:0][31:0]    qd_d, data_q;
  logic [NMULT-1:0]          sat_d, sat_q;
  logic [CNTW-1:0]           cnt_q;

  assign acc_w  = accumulator_i;
  assign nm_w   = norm_mult_i;
  assign ctl_in = '{mode: mode_i, rnd: round_i,
                    q: '{shift: shift_i, relu: relu_i, qbits: qbits_i, qsigned: qsigned_i}};

  // Elastic handshake: a stage may advance when empty or when its successor advances.
  assign rdy3       = !vld_q[3] | out_ready_i;
  assign rdy2       = !vld_q[2] | rdy3;
  assign rdy1       = !vld_q[1] | rdy2;
  assign in_ready_o = rdy1 & !clear_i;

  // S1: byte-wise products; only the top byte of each group may carry a sign.
  for (genvar i = 0; i < NMULT; i++) begin : g_s1
    localparam logic [LW-1:0] SEL8  = LW'(i);
    localparam logic [LW-1:0] SEL16 = LW'(i/2);
    localparam logic [LW-1:0] SEL32 = LW'(i/4);
    localparam logic          TOP16 = (i % 2) == 1;
    localparam logic          TOP32 = (i % 4) == 3;
    logic [LW-1:0]         sel;
    logic                  top;
    logic signed [PW-1:0]  a, m;
    assign sel       = (mode_i == 2'b01) ? SEL16 : (mode_i == 2'b10) ? SEL32 : SEL8;
    assign top       = (mode_i == 2'b01) ? TOP16 : (mode_i == 2'b10) ? TOP32 : 1'b1;
    assign a         = PW'($signed(acc_w[sel]));
    assign m         = PW'($signed({norm_signed_i & top & nm_w[i][NMS-1], nm_w[i]}));
    assign prod_d[i] = a * m;
  end

  // S2: weighted sum of group products plus round-half-up bias.
  for (genvar k = 0; k < NMULT; k++) begin : g_s2
    logic signed [INT-1:0] c8, c16, c32, csel, rnd;
    logic [SHW-1:0]        sh;
    assign sh = ctl1_q.q.shift[k];
    assign c8 = INT'($signed(prod_q[k]));
    if (2*k+1 < NMULT) begin : g_c16
      assign c16 = INT'($signed(prod_q[2*k])) + (INT'($signed(prod_q[2*k+1])) <<< 8);
    end else begin : g_c16
      assign c16 = '0;
    end
    if (4*k+3 < NMULT) begin : g_c32
      assign c32 = INT'($signed(prod_q[4*k]))
                 + (INT'($signed(prod_q[4*k+1])) <<< 8)
                 + (INT'($signed(prod_q[4*k+2])) <<< 16)
                 + (INT'($signed(prod_q[4*k+3])) <<< 24);
    end else begin : g_c32
      assign c32 = '0;
    end
    assign csel     = (ctl1_q.mode == 2'b01) ? c16 : (ctl1_q.mode == 2'b10) ? c32 : c8;
    assign act_d[k] = (ctl1_q.mode == 2'b01) ? (k < NMULT/2) :
                      (ctl1_q.mode == 2'b10) ? (k < NMULT/4) : 1'b1;
    assign rnd       = (ctl1_q.rnd && sh != '0) ? (ONE <<< (sh - SHW'(1))) : '0;
    assign comb_d[k] = csel + rnd;
  end

  // S3: per-lane quantisers feeding the output register.
  ne16_nq_lane #(.INT(INT), .SHW(SHW)) u_lane [NMULT-1:0] (
    .comb_i    (comb_q),
    .shift_i   (ctl2_q.shift),
    .relu_i    (ctl2_q.relu),
    .qbits_i   (ctl2_q.qbits),
    .qsigned_i (ctl2_q.qsigned),
    .active_i  (act_q),
    .data_o    (qd_d),
    .sat_o     (sat_d)
  );

  // Stage valid chain; clear empties every stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      vld_q <= '0;
    else if (clear_i) vld_q <= '0;
    else begin
      if (rdy1) vld_q[1] <= in_valid_i;
      if (rdy2) vld_q[2] <= vld_q[1];
      if (rdy3) vld_q[3] <= vld_q[2];
    end
  end

  // Stage data registers load only when a beat actually moves in, otherwise hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q <= '0; ctl1_q <= '0;
      comb_q <= '0; act_q  <= '0; ctl2_q <= '0;
      data_q <= '0; sat_q  <= '0;
    end else begin
      if (in_valid_i && in_ready_o) begin
        prod_q <= prod_d;
        ctl1_q <= ctl_in;
      end
      if (rdy2 && vld_q[1]) begin
        comb_q <= comb_d;
        act_q  <= act_d;
        ctl2_q <= ctl1_q.q;
      end
      if (rdy3 && vld_q[2]) begin
        data_q <= qd_d;
        sat_q  <= sat_d;
      end
    end
  end

  // Sticky saturation counter: counts saturated output handshakes, holds at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      cnt_q <= '0;
    else if (clear_i) cnt_q <= '0;
    else if (vld_q[3] && out_ready_i && |sat_q && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

  assign out_valid_o = vld_q[3];
  assign data_o      = data_q;
  assign sat_o       = sat_q;
  assign sat_count_o = cnt_q;
endmodule

// File: tb/tb_ne16_normquant_stream.sv
// Self-checking bench for ne16_normquant_stream: directed cases plus a
// randomized stream scored against a plain-arithmetic reference model.
module tb_ne16_normquant_stream;
  typedef struct {
    logic [127:0] acc;
    logic [31:0]  nm;
    logic [23:0]  sh;
    logic [1:0]   mode;
    logic         nsig, rnd, relu, qs;
    logic [1:0]   qb;
  } beat_t;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   sat;
  } exp_t;

  logic         clk = 0, rst_n, clear, in_valid, out_ready;
  logic         nsig, rnd, relu, qs;
  logic [1:0]   mode, qb;
  logic [127:0] acc;
  logic [31:0]  nm;
  logic [23:0]  sh;
  logic         in_ready, out_valid;
  logic [127:0] data;
  logic [3:0]   sat;
  logic [15:0]  cnt;

  int           checks = 0, errors = 0;
  exp_t         sb[$];
  logic [15:0]  cnt_exp;
  logic         stall_prev;
  logic [127:0] hold_data;
  logic [3:0]   hold_sat;

  ne16_normquant_stream dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .accumulator_i(acc), .norm_mult_i(nm), .shift_i(sh), .mode_i(mode),
    .norm_signed_i(nsig), .round_i(rnd), .relu_i(relu), .qbits_i(qb), .qsigned_i(qs),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .data_o(data), .sat_o(sat), .sat_count_o(cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: group multiplier taken as one G-byte integer, result = acc * M,
  // then round, floor-divide by 2^shift, ReLU, clamp.
  function automatic exp_t model(beat_t b);
    exp_t e;
    int g, q;
    logic signed [127:0] a, m, c, hi, lo, one;
    logic [5:0] s;
    e.data = '0; e.sat = '0; one = 1;
    g = (b.mode == 2'b01) ? 2 : (b.mode == 2'b10) ? 4 : 1;
    q = (b.qb == 2'b01) ? 16 : (b.qb == 2'b10) ? 32 : 8;
    for (int k = 0; k < 4/g; k++) begin
      a = $signed(b.acc[k*32 +: 32]);
      m = 0;
      for (int j = 0; j < g; j++) m = m + (128'(b.nm[(k*g+j)*8 +: 8]) << (8*j));
      if (b.nsig && b.nm[(k*g+g)*8-1]) m = m - (one <<< (8*g));
      c = a * m;
      s = b.sh[k*6 +: 6];
      if (b.rnd && s != 0) c = c + (one <<< (s - 1));
      c = c >>> s;
      if (b.relu && c[127]) c = '0;
      hi = b.qs ? (one <<< (q-1)) - one : (one <<< q) - one;
      lo = b.qs ? -(one <<< (q-1)) : '0;
      if (c > hi) begin c = hi; e.sat[k] = 1'b1; end
      else if (c < lo) begin c = lo; e.sat[k] = 1'b1; end
      e.data[k*32 +: 32] = c[31:0];
    end
    return e;
  endfunction

  function automatic beat_t cur_beat();
    beat_t b;
    b.acc = acc; b.nm = nm; b.sh = sh; b.mode = mode; b.nsig = nsig;
    b.rnd = rnd; b.relu = relu; b.qb = qb; b.qs = qs;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    for (int k = 0; k < 4; k++)
      b.acc[k*32 +: 32] = ($urandom % 2) ? $urandom : 32'($urandom_range(0, 4000)) - 32'd2000;
    b.nm = $urandom;
    for (int k = 0; k < 4; k++) b.sh[k*6 +: 6] = 6'($urandom_range(0, 40));
    b.mode = 2'($urandom); b.qb = 2'($urandom);
    b.nsig = 1'($urandom); b.rnd = 1'($urandom); b.relu = 1'($urandom); b.qs = 1'($urandom);
    return b;
  endfunction

  function automatic beat_t mk(logic [127:0] a, logic [31:0] n, logic [23:0] s, logic [1:0] md,
                               logic ns, logic r, logic rl, logic [1:0] qbits, logic qsg);
    beat_t b;
    b.acc = a; b.nm = n; b.sh = s; b.mode = md; b.nsig = ns;
    b.rnd = r; b.relu = rl; b.qb = qbits; b.qs = qsg;
    return b;
  endfunction

  task automatic apply(input beat_t b);
    acc = b.acc; nm = b.nm; sh = b.sh; mode = b.mode; nsig = b.nsig;
    rnd = b.rnd; relu = b.relu; qb = b.qb; qs = b.qs;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input beat_t b);
    apply(b);
    in_valid = 1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check("send_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic expect_out(input string tag, input logic [127:0] d, input logic [3:0] s);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, data, d);
    check({tag, "_sat"}, sat, s);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    out_ready = 1;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) break;
    end
    check("drain_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: samples on the falling edge, ahead of the next active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete(); cnt_exp = 0; stall_prev = 0;
    end else begin
      check("sat_count", cnt, cnt_exp);
      if (stall_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", data, hold_data);
        check("hold_sat", sat, hold_sat);
      end
      if (clear) check("clear_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("out_without_input", out_valid, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_data", data, e.data);
          check("sb_sat", sat, e.sat);
          if (!clear && |e.sat && cnt_exp != 16'hFFFF) cnt_exp = cnt_exp + 1;
        end
      end
      if (clear) begin
        sb.delete(); cnt_exp = 0;
      end else if (in_valid && in_ready) sb.push_back(model(cur_beat()));
      stall_prev = out_valid && !out_ready && !clear;
      hold_data  = data;
      hold_sat   = sat;
    end
  end

  initial begin
    beat_t b, satb;
    beat_t bp[6];
    int idx, nacc;
    logic hs;

    rst_n = 0; clear = 0; in_valid = 0; out_ready = 1;
    apply(mk('0, '0, '0, 2'b00, 0, 0, 0, 2'b00, 0));
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_data", data, 0);
    check("rst_sat", sat, 0);
    check("rst_count", cnt, 0);
    rst_n = 1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // 8B, latency and saturation in both directions
    b = mk({32'd0, 32'd5, 32'hFFFFFC18, 32'd1000}, 32'h03030303, {4{6'd2}}, 2'b00, 0, 1, 0, 2'b00, 1);
    send(b);
    @(negedge clk); check("lat_c1", out_valid, 0);
    @(negedge clk); check("lat_c2", out_valid, 0);
    @(negedge clk); check("lat_c3", out_valid, 1);
    check("t8b_data", data, {32'd0, 32'd4, 32'hFFFFFF80, 32'd127});
    check("t8b_sat", sat, 4'b0011);
    @(negedge clk); check("t8b_count", cnt, 1);
    @(posedge clk); #1;

    // 16B combine with rounding
    send(mk(128'd1000, 32'h00001234, {18'd0, 6'd16}, 2'b01, 0, 1, 0, 2'b10, 1));
    expect_out("t16b", {96'd0, 32'd71}, 4'b0000);

    // 32B with signed top byte, then same beat with ReLU
    send(mk(128'd2, 32'hFF000000, 24'd0, 2'b10, 1, 0, 0, 2'b10, 1));
    expect_out("t32b", {96'd0, 32'hFE000000}, 4'b0000);
    send(mk(128'd2, 32'hFF000000, 24'd0, 2'b10, 1, 0, 1, 2'b10, 1));
    expect_out("t32b_relu", 128'd0, 4'b0000);
    drain();

    // Back-pressure: six beats against a stalled output
    for (int i = 0; i < 6; i++) bp[i] = rand_beat();
    out_ready = 0; idx = 0; nacc = 0;
    apply(bp[0]); in_valid = 1;
    repeat (5) begin
      @(negedge clk); hs = in_ready;
      @(posedge clk); #1;
      if (hs) begin nacc++; idx++; if (idx < 6) apply(bp[idx]); end
    end
    check("bp_accepted", nacc, 3);
    @(negedge clk); check("bp_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 0; out_ready = 1;
    while (idx < 6) begin send(bp[idx]); idx++; end
    drain();

    // Randomized stream with random gaps and back-pressure
    b = rand_beat(); nacc = 0; in_valid = 0;
    for (int c = 0; c < 3000 && nacc < 80; c++) begin
      if (!in_valid) in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      apply(b);
      @(negedge clk); hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) begin nacc++; b = rand_beat(); in_valid = 0; end
    end
    check("rand_sent", nacc, 80);
    in_valid = 0;
    drain();

    // Clear with two beats in flight and count at 5
    clear = 1; @(posedge clk); #1; clear = 0;
    satb = mk({4{32'd1000}}, 32'h03030303, 24'd0, 2'b00, 0, 0, 0, 2'b00, 1);
    repeat (5) send(satb);
    drain();
    check("cnt_five", cnt, 5);
    send(satb); send(satb);
    apply(satb); in_valid = 1; clear = 1;
    @(negedge clk); check("clr_in_ready", in_ready, 0);
    @(posedge clk); #1; clear = 0; in_valid = 0;
    @(negedge clk);
    check("clr_valid", out_valid, 0);
    check("clr_count", cnt, 0);
    repeat (4) begin @(negedge clk); check("clr_flushed", out_valid, 0); end
    @(posedge clk); #1;

    // Counter saturation at all-ones
    apply(satb); in_valid = 1; out_ready = 1; nacc = 0;
    for (int c = 0; c < 70000 && nacc < 65534; c++) begin
      @(negedge clk); hs = in_ready;
      @(posedge clk); #1;
      if (hs) nacc++;
    end
    in_valid = 0;
    drain();
    check("cnt_fffe", cnt, 16'hFFFE);
    repeat (3) send(satb);
    drain();
    check("cnt_sticky", cnt, 16'hFFFF);

    // Asynchronous reset mid-stream
    send(satb); send(satb);
    #2 rst_n = 0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_count", cnt, 0);
    check("arst_data", data, 0);
    @(posedge clk); #1; rst_n = 1;
    repeat (5) begin @(negedge clk); check("arst_flushed", out_valid, 0); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ne16_normquant_stream.md
Name: ne16_normquant_stream

Overview:
- Pipelined, elastic normalisation/quantisation stage between the NE16 accumulator bank and the streamer output path.
- Multiplies each accumulator lane by a per-lane normalisation multiplier and combines byte products in 8/16/32-bit multiplier modes.
- Then rounds, shifts right arithmetically, applies optional ReLU, and saturates to a configurable output width.
- Carries per-beat control with the data through a 3-stage valid/ready pipeline and keeps a sticky saturation counter.

Parameters:
- NMULT, 4, lanes per beat; power of two, at least 4.
- NMS, 8, bits per normalisation multiplier byte.
- ACC, 32, accumulator lane width (signed).
- SHW, 6, shift amount width.
- CNTW, 16, saturation counter width.
- Localparam INT = ACC+4*NMS+1, intermediate width; no truncation anywhere.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous clear: flush pipeline, zero counter
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  input beat accepted when valid&ready
- accumulator_i  in  NMULT*ACC  signed accumulator lanes
- norm_mult_i  in  NMULT*NMS  multiplier bytes, byte i for lane i
- shift_i  in  NMULT*SHW  right-shift amount per output lane
- mode_i  in  2  00=8B, 01=16B, 10=32B, 11=reserved (treated as 8B)
- norm_signed_i  in  1  MSB byte of each multiplier group is signed
- round_i  in  1  enable round-half-up before shift
- relu_i  in  1  clamp negatives to 0 before saturation
- qbits_i  in  2  output width: 00=8, 01=16, 10=32, 11=8
- qsigned_i  in  1  signed (1) / unsigned (0) saturation range
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  downstream ready
- data_o  out  NMULT*32  quantised lanes, sign- or zero-extended to 32 bits
- sat_o  out  NMULT  per-lane saturation flag, aligned with data_o
- sat_count_o  out  CNTW  output beats with any lane saturated; saturates at all-ones

Behaviour:
- Reset: all stage valids 0, out_valid_o=0, data_o=0, sat_o=0, sat_count_o=0. in_ready_o=1 whenever clear_i=0.
- Pipeline: S1 multiply, S2 combine and round, S3 shift/ReLU/saturate and output register.
- Each stage is ready when its valid is 0 or the next stage is ready. in_ready_o = S1 ready & !clear_i.
- Latency: 3 cycles from input handshake to out_valid_o, with no stalls. Throughput 1 beat/cycle. Order preserved. No beat is dropped or duplicated under any out_ready_i pattern.
- Stalled registers hold data and control stable. out_valid_o never drops without a handshake.
- Control fields are captured with the beat and travel with it, so mode changes between beats are legal.
- S1: product[i] = acc_sel[i] * m[i]. m[i] = {s, byte i}, where s = norm_signed_i & MSB of byte i, applied only if byte i is the top byte of its group; otherwise s=0.
  - Group size G: 1 (8B), 2 (16B), 4 (32B).
  - acc_sel[i] = accumulator lane floor(i/G).
- S2: for group k, combined[k] = sum over j<G of product[k*G+j] <<< (8*j), computed at INT bits.
  - Lane k also uses shift lane k.
  - Round: if round_i and shift>0, add 1<<(shift-1); shift=0 adds nothing.
- S3: v = combined >>> shift (arithmetic; shift >= INT gives 0 or -1). If relu_i and v<0, v=0.
  - Clamp to [-2^(q-1), 2^(q-1)-1] if qsigned_i, else [0, 2^q-1], where q is the qbits width.
  - sat_o[k]=1 iff clamped. ReLU does not count as saturation.
- Active lanes: NMULT/G. Inactive lanes output data 0 and sat 0.
- sat_count_o increments by 1 on each output handshake where any sat_o bit is set. It holds at 2^CNTW-1.
- clear_i: next cycle all valids=0 and sat_count_o=0.
  - An input presented with clear_i is not accepted (in_ready_o=0).
  - An output handshake coinciding with clear_i completes, but is not counted.
- Asynchronous reset mid-stream discards all in-flight beats.

Test Plan:
- 8B, acc lanes {1000,-1000,5,0}, mult 3, shift 2, round, qbits 8 signed -> data {127,-128,4,0}, sat_o=0011, sat_count_o=1, out_valid_o exactly 3 cycles after accept.
- 16B, acc lane0=1000, mult bytes {0x34,0x12}, shift 16, round, qbits 32 signed -> lane0=71, lanes 1..3=0, sat_o=0.
- 32B signed, acc lane0=2, mult bytes {0x00,0x00,0x00,0xFF}, norm_signed=1, shift 0, qbits 32 -> lane0=-33554432. Same beat with relu -> 0, sat_o=0.
- Back-pressure: 6 back-to-back beats with out_ready_i low for 5 cycles -> in_ready_o drops after 3 accepted; all 6 emerge in order, unchanged.
- Clear with 2 beats in flight and sat_count_o=5 -> out_valid_o=0 and sat_count_o=0 the next cycle; simultaneous input not accepted.
- Preload 0xFFFE saturated beats, then 3 more -> sat_count_o sticks at 0xFFFF.
